instruction_fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline: holds the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit word, plus PC+4, into the IF/ID pipeline register.
- Applies stall requests from the hazard unit, and branch/jump redirects and flushes resolved in ID.
- Sits directly upstream of the instruction memory and directly feeds the decode stage.

---
 rtl/instruction_fetch_stage_if.sv | 34 +++
 rtl/instruction_fetch_stage.sv | 92 +++++++++
 tb/tb_instruction_fetch_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
// Module      : instruction_fetch_stage_if
// Description : Control inputs, imem port and IF/ID outputs of the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        flush;
    logic [31:0] instruction;
    logic [31:0] instruction_address;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    // Environment side: hazard unit, ID redirect logic and instruction memory.
    modport master (
        output stall, pc_src, branch_target, jump_index, jr_target, flush, instruction,
        input  instruction_address, if_id_instruction, if_id_pc_plus4, if_id_valid
    );

    // Fetch stage side.
    modport slave (
        input  stall, pc_src, branch_target, jump_index, jr_target, flush, instruction,
        output instruction_address, if_id_instruction, if_id_pc_plus4, if_id_valid
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : MIPS IF stage - PC register, next-PC select, IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 4096,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    instruction_fetch_stage_if.slave       bus
);

    localparam logic [31:0] c_IMEM_LIMIT = 32'(IMEM_BYTES);

    localparam logic [1:0] c_SRC_SEQ    = 2'b00;
    localparam logic [1:0] c_SRC_BRANCH = 2'b01;
    localparam logic [1:0] c_SRC_JUMP   = 2'b10;
    localparam logic [1:0] c_SRC_JR     = 2'b11;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q;
    logic [31:0] if_id_pc_plus4_d;
    logic        if_id_valid_q;
    logic        if_id_valid_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_fetch_in_range;

    assign w_pc_plus4       = pc_q + 32'd4;
    assign w_fetch_in_range = (pc_q < c_IMEM_LIMIT);

    // Jump keeps the region bits of the instruction in ID, i.e. its own PC+4.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (bus.pc_src)
            c_SRC_SEQ:    w_next_pc = w_pc_plus4;
            c_SRC_BRANCH: w_next_pc = {bus.branch_target[31:2], 2'b00};
            c_SRC_JUMP:   w_next_pc = {if_id_pc_plus4_q[31:28], bus.jump_index, 2'b00};
            c_SRC_JR:     w_next_pc = {bus.jr_target[31:2], 2'b00};
            default:      w_next_pc = w_pc_plus4;
        endcase
    end

    always_comb begin
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        if (!bus.stall) begin
            pc_d             = {w_next_pc[31:2], 2'b00};
            if_id_pc_plus4_d = w_pc_plus4;
            if (bus.flush || !w_fetch_in_range) begin
                if_id_instr_d = NOP_WORD;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_instr_d = bus.instruction;
                if_id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            if_id_instr_q    <= NOP_WORD;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

    assign bus.instruction_address = pc_q;
    assign bus.if_id_instruction   = if_id_instr_q;
    assign bus.if_id_pc_plus4      = if_id_pc_plus4_q;
    assign bus.if_id_valid         = if_id_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem [0:1023];

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (4096),
        .NOP_WORD   (c_NOP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return garbage.
    always_comb begin
        if (bus.instruction_address < 32'd4096)
            bus.instruction = mem[bus.instruction_address[11:2]];
        else
            bus.instruction = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[2] = 32'h0022_1821;
        mem[3] = 32'h0043_2024;

        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.pc_src        = 2'b00;
        bus.branch_target = 32'd0;
        bus.jump_index    = 26'd0;
        bus.jr_target     = 32'd0;
        bus.flush         = 1'b0;

        step();
        step();
        chk("rst_addr",  bus.instruction_address, 32'd0);
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_instr", bus.if_id_instruction, c_NOP);
        chk("rst_pc4",   bus.if_id_pc_plus4, 32'd0);
        rst = 1'b0;

        step();
        chk("run1_instr", bus.if_id_instruction, 32'hA000_0000);
        chk("run1_valid", {31'd0, bus.if_id_valid}, 32'd1);
        step();
        step();
        chk("run3_instr", bus.if_id_instruction, 32'h0022_1821);
        chk("run3_pc4",   bus.if_id_pc_plus4, 32'd12);
        chk("run3_addr",  bus.instruction_address, 32'd12);

        bus.stall = 1'b1;
        step();
        chk("stall1_addr",  bus.instruction_address, 32'd12);
        chk("stall1_instr", bus.if_id_instruction, 32'h0022_1821);
        step();
        chk("stall2_addr",  bus.instruction_address, 32'd12);
        chk("stall2_instr", bus.if_id_instruction, 32'h0022_1821);
        bus.stall = 1'b0;
        step();
        chk("release_addr",  bus.instruction_address, 32'd16);
        chk("release_instr", bus.if_id_instruction, 32'h0043_2024);
        chk("release_pc4",   bus.if_id_pc_plus4, 32'd16);

        bus.pc_src        = 2'b01;
        bus.branch_target = 32'h0000_0043;
        bus.flush         = 1'b1;
        step();
        chk("br_addr",  bus.instruction_address, 32'h0000_0040);
        chk("br_instr", bus.if_id_instruction, c_NOP);
        chk("br_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("br_pc4",   bus.if_id_pc_plus4, 32'd20);
        bus.pc_src = 2'b00;
        bus.flush  = 1'b0;
        step();
        chk("br_tgt_instr", bus.if_id_instruction, 32'hA000_0010);
        chk("br_tgt_valid", {31'd0, bus.if_id_valid}, 32'd1);
        chk("br_tgt_pc4",   bus.if_id_pc_plus4, 32'h0000_0044);

        // jr with misaligned target, then a jump from PC 0x10000004's successor
        bus.pc_src    = 2'b11;
        bus.jr_target = 32'h1000_0007;
        step();
        chk("jr_addr", bus.instruction_address, 32'h1000_0004);
        bus.pc_src = 2'b00;
        step();
        chk("oor_hi_pc4",   bus.if_id_pc_plus4, 32'h1000_0008);
        chk("oor_hi_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("oor_hi_instr", bus.if_id_instruction, c_NOP);
        bus.pc_src     = 2'b10;
        bus.jump_index = 26'h000_0010;
        step();
        chk("jump_addr", bus.instruction_address, 32'h1000_0040);

        bus.stall     = 1'b1;
        bus.flush     = 1'b1;
        bus.pc_src    = 2'b11;
        bus.jr_target = 32'h0000_0123;
        step();
        chk("sf_addr", bus.instruction_address, 32'h1000_0040);
        chk("sf_pc4",  bus.if_id_pc_plus4, 32'h1000_000C);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        bus.pc_src    = 2'b11;
        bus.jr_target = 32'd4092;
        step();
        chk("to4092_addr", bus.instruction_address, 32'd4092);
        bus.pc_src = 2'b00;
        step();
        chk("f4092_instr", bus.if_id_instruction, 32'hA000_03FF);
        chk("f4092_valid", {31'd0, bus.if_id_valid}, 32'd1);
        chk("f4092_addr",  bus.instruction_address, 32'd4096);
        step();
        chk("f4096_instr", bus.if_id_instruction, c_NOP);
        chk("f4096_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("f4096_addr",  bus.instruction_address, 32'd4100);

        rst                = 1'b1;
        bus.pc_src         = 2'b01;
        bus.branch_target  = 32'h0000_0800;
        step();
        chk("rst2_addr",  bus.instruction_address, 32'd0);
        chk("rst2_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst2_pc4",   bus.if_id_pc_plus4, 32'd0);
        rst = 1'b0;

        bus.pc_src    = 2'b11;
        bus.jr_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre", bus.instruction_address, 32'hFFFF_FFFC);
        bus.pc_src = 2'b00;
        step();
        chk("wrap_addr", bus.instruction_address, 32'd0);
        chk("wrap_pc4",  bus.if_id_pc_plus4, 32'd0);

        // flush with no redirect squashes one word, PC still advances
        bus.flush = 1'b1;
        step();
        chk("fl_addr",  bus.instruction_address, 32'd4);
        chk("fl_valid", {31'd0, bus.if_id_valid}, 32'd0);
        bus.flush = 1'b0;
        step();
        chk("fl_next_instr", bus.if_id_instruction, 32'hA000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
